fsmc_master_if: RTL and testbench
=================================

// Module: fsmc_master_if
// PURPOSE
//  Initiator side of the 16-bit async SRAM-like FSMC bus (Mode A, NE/NOE/NWE, non-muxed A/D).
//  - Turns a valid/ready request stream into timed FSMC read/write cycles.
//  - Uses: MCU bus model in benches for fsmc_sync_if/regBank; FPGA-side driver of external SRAM-like parts.
//  - Data pins split into D_o/D_oe/D_i; tri-state buffer sits in the parent, as fpga_IOBuf or sim assign.
// PARAMETERS
//  p_WIDTH_ADDR  16  address width
//  p_WIDTH_DATA  16  data width
//  p_ADDSET      2   address-setup phase, clk cycles (0 treated as 1)
//  p_DATAST      4   data phase, clk cycles (0 treated as 1)
//  p_BUSTURN     1   bus-turnaround phase after NE release, clk cycles (0 allowed)
// PORTS
//  clk          in   1      system clock, single clock domain
//  rst_n        in   1      asynchronous active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      block can accept a request (state IDLE)
//  req_wr       in   1      1=write, 0=read
//  req_addr     in   AW     bus address
//  req_wdata    in   DW     write data
//  rsp_valid    out  1      1-cycle completion pulse, reads and writes
//  rsp_rdata    out  DW     last read data, held until next read completes
//  fsmc_A       out  AW     address pins
//  fsmc_D_o     out  DW     data to drive
//  fsmc_D_oe    out  1      data pin output enable
//  fsmc_D_i     in   DW     data from pins
//  fsmc_NE      out  1      chip enable, active low
//  fsmc_NWE     out  1      write strobe, active low
//  fsmc_NOE     out  1      output enable, active low
// BEHAVIOUR
//  - All fsmc_* outputs, req_ready, rsp_* are registered; no strobe glitches.
//  - Reset: state IDLE, NE=NWE=NOE=1, A=0, D_o=0, D_oe=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
//  - FSM IDLE->ADDSET->DATAST->HOLD->BUSTURN->IDLE. BUSTURN is skipped when its count is 0.
//  - IDLE: req_ready=1. Handshake on req_valid&req_ready latches wr/addr/wdata, then goes to ADDSET.
//  - ADDSET (N_A cycles): NE=0, A valid, NOE=NWE=1; for a write, D_o=wdata and D_oe=1.
//  - DATAST (N_D cycles): read NOE=0; write NWE=0 with D_oe=1.
//  - Read capture: fsmc_D_i is sampled at the closing edge of the last DATAST cycle.
//  - HOLD (1 cycle): NE=0, NOE=NWE=1, A and write data still driven.
//  - rsp_valid=1 in the HOLD cycle only; for a read, rsp_rdata is updated in the same cycle.
//  - BUSTURN (N_T cycles): NE=1, D_oe=0, A held.
//  - Cycle length: NE low for N_A+N_D+1 cycles; NWE/NOE low for exactly N_D cycles.
//  - Accept-to-accept = 1+N_A+N_D+1+N_T cycles; NE high between cycles >= N_T+1.
//  - NWE and NOE are never low together; D_oe is never high during a read.
//  - req_* inputs are ignored outside IDLE; there is no queueing.
//  - Reset mid-operation: strobes go high and D_oe goes low immediately (async); pending response is dropped.
//  - Phase counters are sized to hold max(p_*) (4-bit when runtime timing is enabled); no wrap inside a phase.
// CONFIGURATION
//  FSMC_MASTER_RUNTIME_TIMING_EN defined:
//  - Adds inputs cfg_addset[3:0], cfg_datast[3:0], cfg_busturn[3:0]; these replace p_ADDSET/p_DATAST/p_BUSTURN.
//  - Values are sampled at the accept edge and are constant for that transaction; 0 rules unchanged.
//  Not defined: the cfg ports do not exist and timing is fixed by the parameters.
// TESTING
//  - Write A=0x0010 D=0xA5A5 (defaults 2/4/1) -> NE low 7 cycles, NWE low 4, D_oe high 7, rsp_valid once, ready after 9.
//  - Read A=0x0020, model drives 0x1234 while NOE=0 -> NOE low 4 cycles, rsp_rdata=0x1234 with rsp_valid.
//  - req_valid held high for 3 back-to-back writes, p_BUSTURN=0 -> NE high exactly 1 cycle between each.
//  - p_ADDSET=0, p_DATAST=0 -> behaves as 1/1: NE low 3 cycles, strobe low 1 cycle.
//  - rst_n low during DATAST of a write -> NWE=1, D_oe=0 same cycle; no rsp_valid; next request runs normally.
//  - Loopback via sim IOBuf into fsmc_sync_if+regBank: write num1..3=1,2,3, set sys_en, read sum -> 0x0006.

Source files
------------

// File: rtl/fsmc_master_if_if.sv
// ----------------------------------------------------------------------------
// fsmc_master_if_if
// Request/response stream between a requester and the FSMC initiator.
//   req_valid  requester -> initiator  request present
//   req_ready  initiator -> requester  initiator idle, can accept
//   req_wr     requester -> initiator  1=write, 0=read
//   req_addr   requester -> initiator  bus address
//   req_wdata  requester -> initiator  write data
//   rsp_valid  initiator -> requester  1-cycle completion pulse
//   rsp_rdata  initiator -> requester  last read data
// Modports: master = requester side, slave = FSMC initiator side.
// ----------------------------------------------------------------------------
interface fsmc_master_if_if #(
    parameter int p_WIDTH_ADDR = 16,
    parameter int p_WIDTH_DATA = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wr;
    logic [p_WIDTH_ADDR-1:0] req_addr;
    logic [p_WIDTH_DATA-1:0] req_wdata;
    logic                    rsp_valid;
    logic [p_WIDTH_DATA-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/fsmc_master_if.sv
// ----------------------------------------------------------------------------
// fsmc_master_if
// Initiator side of a 16-bit async SRAM-like FSMC bus (Mode A, NE/NOE/NWE,
// non-muxed A/D). Converts a valid/ready request stream into timed read and
// write cycles. The data pins are split into D_o/D_oe/D_i; the tri-state
// buffer lives in the parent.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_if         request/response stream (slave modport)
//   cfg_addset/cfg_datast/cfg_busturn  runtime phase lengths (only with
//                  FSMC_MASTER_RUNTIME_TIMING_EN defined)
//   fsmc_A         address pins
//   fsmc_D_o       data to drive, fsmc_D_oe its output enable
//   fsmc_D_i       data from pins
//   fsmc_NE/NWE/NOE  active-low chip enable, write strobe, output enable
//
// Optional feature: define FSMC_MASTER_RUNTIME_TIMING_EN to take the phase
// lengths from the cfg_* inputs (sampled at the accept edge) instead of the
// p_ADDSET/p_DATAST/p_BUSTURN parameters.
//
// FSM states
//   state     | meaning
//   S_IDLE    | ready for a request, bus released
//   S_ADDSET  | NE low, address (and write data) set up, strobes high
//   S_DATAST  | NOE (read) or NWE (write) low
//   S_HOLD    | strobes released, NE still low, response pulse
//   S_BUSTURN | NE high, data pins released, address held
// ----------------------------------------------------------------------------
module fsmc_master_if #(
    parameter int p_WIDTH_ADDR = 16,
    parameter int p_WIDTH_DATA = 16,
    parameter int p_ADDSET     = 2,
    parameter int p_DATAST     = 4,
    parameter int p_BUSTURN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef FSMC_MASTER_RUNTIME_TIMING_EN
    input  logic [3:0]              cfg_addset,
    input  logic [3:0]              cfg_datast,
    input  logic [3:0]              cfg_busturn,
`endif
    fsmc_master_if_if.slave         req_if,
    output logic [p_WIDTH_ADDR-1:0] fsmc_A,
    output logic [p_WIDTH_DATA-1:0] fsmc_D_o,
    output logic                    fsmc_D_oe,
    input  logic [p_WIDTH_DATA-1:0] fsmc_D_i,
    output logic                    fsmc_NE,
    output logic                    fsmc_NWE,
    output logic                    fsmc_NOE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDSET  = 3'd1;
    localparam logic [2:0] S_DATAST  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_BUSTURN = 3'd4;

`ifdef FSMC_MASTER_RUNTIME_TIMING_EN
    localparam int CW = 4;
`else
    localparam int N_A   = (p_ADDSET == 0) ? 1 : p_ADDSET;
    localparam int N_D   = (p_DATAST == 0) ? 1 : p_DATAST;
    localparam int N_MAX = (N_A > N_D) ? ((N_A > p_BUSTURN) ? N_A : p_BUSTURN)
                                       : ((N_D > p_BUSTURN) ? N_D : p_BUSTURN);
    // counter holds phase length minus one
    localparam int CW    = (N_MAX < 2) ? 1 : $clog2(N_MAX);
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          wr_q;

    // phase counter reload values (length minus one) and busturn presence
    logic [CW-1:0] acc_ld_a;
    logic [CW-1:0] ld_d;
    logic [CW-1:0] ld_t;
    logic          turn_en;

    logic          accept;
    assign accept = (state == S_IDLE) && req_if.req_valid;

`ifdef FSMC_MASTER_RUNTIME_TIMING_EN
    logic [3:0] d_m1_q;
    logic [3:0] t_m1_q;
    logic       t_en_q;

    // address-setup length is needed on the accept edge itself, so it comes
    // straight from the input; the later phases use the values latched there
    assign acc_ld_a = (cfg_addset == 4'd0) ? 4'd0 : cfg_addset - 4'd1;
    assign ld_d     = d_m1_q;
    assign ld_t     = t_m1_q;
    assign turn_en  = t_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_m1_q <= 4'd0;
            t_m1_q <= 4'd0;
            t_en_q <= 1'b0;
        end else if (accept) begin
            d_m1_q <= (cfg_datast == 4'd0) ? 4'd0 : cfg_datast - 4'd1;
            t_m1_q <= (cfg_busturn == 4'd0) ? 4'd0 : cfg_busturn - 4'd1;
            t_en_q <= (cfg_busturn != 4'd0);
        end
    end
`else
    assign acc_ld_a = CW'(N_A - 1);
    assign ld_d     = CW'(N_D - 1);
    assign ld_t     = (p_BUSTURN == 0) ? '0 : CW'(p_BUSTURN - 1);
    assign turn_en  = (p_BUSTURN != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            wr_q             <= 1'b0;
            fsmc_A           <= '0;
            fsmc_D_o         <= '0;
            fsmc_D_oe        <= 1'b0;
            fsmc_NE          <= 1'b1;
            fsmc_NWE         <= 1'b1;
            fsmc_NOE         <= 1'b1;
            req_if.req_ready <= 1'b1;
            req_if.rsp_valid <= 1'b0;
            req_if.rsp_rdata <= '0;
        end else begin
            req_if.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wr_q             <= req_if.req_wr;
                        fsmc_A           <= req_if.req_addr;
                        if (req_if.req_wr)
                            fsmc_D_o <= req_if.req_wdata;
                        fsmc_D_oe        <= req_if.req_wr;
                        fsmc_NE          <= 1'b0;
                        req_if.req_ready <= 1'b0;
                        cnt              <= acc_ld_a;
                        state            <= S_ADDSET;
                    end
                end
                S_ADDSET: begin
                    if (cnt == '0) begin
                        cnt   <= ld_d;
                        state <= S_DATAST;
                        if (wr_q)
                            fsmc_NWE <= 1'b0;
                        else
                            fsmc_NOE <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DATAST: begin
                    if (cnt == '0) begin
                        fsmc_NWE         <= 1'b1;
                        fsmc_NOE         <= 1'b1;
                        req_if.rsp_valid <= 1'b1;
                        // closing edge of the last data cycle: pins still enabled
                        if (!wr_q)
                            req_if.rsp_rdata <= fsmc_D_i;
                        state            <= S_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    fsmc_NE   <= 1'b1;
                    fsmc_D_oe <= 1'b0;
                    if (turn_en) begin
                        cnt   <= ld_t;
                        state <= S_BUSTURN;
                    end else begin
                        req_if.req_ready <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                S_BUSTURN: begin
                    if (cnt == '0) begin
                        req_if.req_ready <= 1'b1;
                        state            <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    fsmc_NE          <= 1'b1;
                    fsmc_NWE         <= 1'b1;
                    fsmc_NOE         <= 1'b1;
                    fsmc_D_oe        <= 1'b0;
                    req_if.req_ready <= 1'b1;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsmc_master_if.sv
// ----------------------------------------------------------------------------
// tb_fsmc_master_if
// Two initiators: u0 with default timing (2/4/1) and u1 with 0/0/0 timing
// (behaves as 1/1/0). Each drives a small SRAM device model. Expected bus
// waveforms are derived from phase lengths: cycle k after the accept edge.
// ----------------------------------------------------------------------------
module tb_fsmc_master_if;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fsmc_master_if_if #(.p_WIDTH_ADDR(16), .p_WIDTH_DATA(16)) if0 ();
    fsmc_master_if_if #(.p_WIDTH_ADDR(16), .p_WIDTH_DATA(16)) if1 ();

    wire [1:0][15:0] a, d_o, d_i, rd;
    wire [1:0]       oe, ne, nwe, noe, rv, rdy;

    fsmc_master_if #(.p_ADDSET(2), .p_DATAST(4), .p_BUSTURN(1)) u0 (
        .clk(clk), .rst_n(rst_n),
`ifdef FSMC_MASTER_RUNTIME_TIMING_EN
        .cfg_addset(4'd2), .cfg_datast(4'd4), .cfg_busturn(4'd1),
`endif
        .req_if(if0.slave),
        .fsmc_A(a[0]), .fsmc_D_o(d_o[0]), .fsmc_D_oe(oe[0]), .fsmc_D_i(d_i[0]),
        .fsmc_NE(ne[0]), .fsmc_NWE(nwe[0]), .fsmc_NOE(noe[0])
    );

    fsmc_master_if #(.p_ADDSET(0), .p_DATAST(0), .p_BUSTURN(0)) u1 (
        .clk(clk), .rst_n(rst_n),
`ifdef FSMC_MASTER_RUNTIME_TIMING_EN
        .cfg_addset(4'd0), .cfg_datast(4'd0), .cfg_busturn(4'd0),
`endif
        .req_if(if1.slave),
        .fsmc_A(a[1]), .fsmc_D_o(d_o[1]), .fsmc_D_oe(oe[1]), .fsmc_D_i(d_i[1]),
        .fsmc_NE(ne[1]), .fsmc_NWE(nwe[1]), .fsmc_NOE(noe[1])
    );

    assign rdy[0] = if0.req_ready;
    assign rdy[1] = if1.req_ready;
    assign rv[0]  = if0.rsp_valid;
    assign rv[1]  = if1.rsp_valid;
    assign rd[0]  = if0.rsp_rdata;
    assign rd[1]  = if1.rsp_rdata;

    // SRAM device models: written on NWE rising, drive data while NOE low
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    always @(posedge nwe[0]) mem0[a[0][7:0]] <= d_o[0];
    always @(posedge nwe[1]) mem1[a[1][7:0]] <= d_o[1];
    assign d_i[0] = noe[0] ? 16'hBAD0 : mem0[a[0][7:0]];
    assign d_i[1] = noe[1] ? 16'hBAD1 : mem1[a[1][7:0]];

    // expected state of the system
    logic [15:0] exp_mem [2][256];
    logic [15:0] last_rd [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int i, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d got=%h exp=%h", nm, i, k, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [15:0] ad, input logic [15:0] wd);
        if (i == 0) begin
            if0.req_valid = v; if0.req_wr = w; if0.req_addr = ad; if0.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_wr = w; if1.req_addr = ad; if1.req_wdata = wd;
        end
    endtask

    function automatic logic [5:0] ctl(input int i);
        return {ne[i], nwe[i], noe[i], oe[i], rv[i], rdy[i]};
    endfunction

    // One transaction checked cycle by cycle against the phase-length rules.
    task automatic run_txn(input int i, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic use_exp,
                           input logic [15:0] exp_rd);
        int na, nd, nt, hold, len;
        logic [15:0] exp_new;
        logic [5:0]  exp_ctl;
        logic [15:0] exp_r;
        na      = (i == 0) ? 2 : 1;
        nd      = (i == 0) ? 4 : 1;
        nt      = (i == 0) ? 1 : 0;
        hold    = na + nd + 1;
        len     = hold + nt + 1;
        exp_new = use_exp ? exp_rd : exp_mem[i][addr[7:0]];
        chk("ready_before", i, 0, 32'(rdy[i]), 32'd1);
        set_req(i, 1'b1, wr, addr, wdata);
        tick();
        for (int k = 1; k <= len; k++) begin
            // garbage requests while busy must be ignored
            set_req(i, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
            exp_ctl = {1'(k > hold),
                       1'(!(wr && k > na && k < hold)),
                       1'(!(!wr && k > na && k < hold)),
                       1'(wr && k <= hold),
                       1'(k == hold),
                       1'(k == len)};
            chk("ctl", i, k, 32'(ctl(i)), 32'(exp_ctl));
            chk("addr", i, k, 32'(a[i]), 32'(addr));
            if (wr && k <= hold)
                chk("wdata", i, k, 32'(d_o[i]), 32'(wdata));
            exp_r = (!wr && k >= hold) ? exp_new : last_rd[i];
            chk("rdata", i, k, 32'(rd[i]), 32'(exp_r));
            if (k < len) begin
                set_req(i, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
                tick();
            end
        end
        if (wr) exp_mem[i][addr[7:0]] = wdata;
        else    last_rd[i] = exp_new;
    endtask

    initial begin
        int rvcnt;
        for (int j = 0; j < 256; j++) begin
            mem0[j] = 16'h0000; mem1[j] = 16'h0000;
            exp_mem[0][j] = 16'h0000; exp_mem[1][j] = 16'h0000;
        end
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;

        vecs[0] = '{0, 1'b1, 16'h0010, 16'hA5A5, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5};
        vecs[2] = '{0, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        vecs[3] = '{0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[4] = '{1, 1'b1, 16'h0003, 16'hFFFF, 16'h0000};
        vecs[5] = '{1, 1'b0, 16'h0003, 16'h0000, 16'hFFFF};
        vecs[6] = '{1, 1'b0, 16'h0005, 16'h0000, 16'h0000};
        vecs[7] = '{0, 1'b0, 16'h0099, 16'h0000, 16'h0000};

        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ctl", i, 0, 32'(ctl(i)), 32'h39);
            chk("rst_addr", i, 0, 32'(a[i]), 32'h0);
            chk("rst_dout", i, 0, 32'(d_o[i]), 32'h0);
            chk("rst_rdata", i, 0, 32'(rd[i]), 32'h0);
        end
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++)
            run_txn(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                    1'b1, vecs[v].exp_rdata);

        // three back-to-back writes on u1 with req_valid held high
        rvcnt = 0;
        set_req(1, 1'b1, 1'b1, 16'h0007, 16'h0B0B);
        tick();
        for (int k = 1; k <= 12; k++) begin
            chk("b2b_ne", 1, k, 32'(ne[1]), 32'((k % 4) == 0));
            chk("b2b_nwe", 1, k, 32'(nwe[1]), 32'((k % 4) != 2));
            if (rv[1]) rvcnt++;
            if (k == 12) set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
            else tick();
        end
        chk("b2b_rsp_count", 1, 12, 32'(rvcnt), 32'd3);
        exp_mem[1][8'h07] = 16'h0B0B;
        run_txn(1, 1'b0, 16'h0007, 16'h0, 1'b1, 16'h0B0B);

        // reset in the middle of a write data phase on u0
        set_req(0, 1'b1, 1'b1, 16'h0080, 16'h5555);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) tick();
        chk("mid_nwe", 0, 4, 32'(nwe[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", 0, 4, 32'(ctl(0)), 32'h39);
        tick();
        rst_n = 1'b1;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post_rst_quiet", 0, k, 32'({rv[0], rdy[0], ne[0]}), 32'h3);
        end
        run_txn(0, 1'b1, 16'h0011, 16'hC3C3, 1'b1, 16'h0);
        run_txn(0, 1'b0, 16'h0011, 16'h0, 1'b1, 16'hC3C3);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            int          i;
            logic        w;
            logic [15:0] ad;
            i  = int'($urandom_range(1, 0));
            w  = 1'($urandom);
            ad = {8'($urandom), 2'b00, 6'($urandom)};
            repeat ($urandom_range(2, 0)) tick();
            run_txn(i, w, ad, 16'($urandom), 1'b0, 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
